// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: grants the fetch or load/store requester, drives the
// memory strobe, waits the fixed read latency and returns data/ack to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             owner_we_reg, owner_we_next;
  logic             last_reg, last_next;
  logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;

  logic grant_any;
  logic grant_port;
  logic done_pulse;

  // Grant decision is combinational on the request lines while idle.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = PORT_IF;
    if (!reset && state_reg == IDLE) begin
      if (if_req && d_req) begin
        grant_any  = 1'b1;
        grant_port = ~last_reg;
      end else if (d_req) begin
        grant_any  = 1'b1;
        grant_port = PORT_D;
      end else if (if_req) begin
        grant_any  = 1'b1;
        grant_port = PORT_IF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= PORT_IF;
      owner_we_reg <= 1'b0;
      last_reg     <= PORT_IF;
      lat_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      owner_we_reg <= owner_we_next;
      last_reg     <= last_next;
      lat_cnt_reg  <= lat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    owner_we_next = owner_we_reg;
    last_next     = last_reg;
    lat_cnt_next  = lat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          state_next    = WAIT;
          owner_next    = grant_port;
          last_next     = grant_port;
          owner_we_next = (grant_port == PORT_D) ? d_we : 1'b0;
          lat_cnt_next  = LAT_W'(1);
        end
      end
      WAIT: begin
        if (lat_cnt_reg == LAT_LAST) begin
          state_next   = IDLE;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign done_pulse = !reset && (state_reg == WAIT) && (lat_cnt_reg == LAT_LAST);

  always_comb begin
    mem_en    = grant_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = !reset && (state_reg == WAIT);
    if (grant_any) begin
      if (grant_port == PORT_D) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_addr  = if_addr;
      end
    end
  end

  // Per-port handshake outputs; index 0 is fetch, index 1 is load/store.
  logic              gnt_vec   [2];
  logic              valid_vec [2];
  logic [DATA_W-1:0] rdata_vec [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_ID = (gi == 0) ? PORT_IF : PORT_D;
      assign gnt_vec[gi]   = grant_any && (grant_port == PORT_ID);
      assign valid_vec[gi] = done_pulse && (owner_reg == PORT_ID);
      assign rdata_vec[gi] = (valid_vec[gi] && !owner_we_reg) ? mem_rdata : '0;
    end
  endgenerate

  assign if_gnt   = gnt_vec[0];
  assign if_valid = valid_vec[0];
  assign if_rdata = rdata_vec[0];
  assign d_gnt    = gnt_vec[1];
  assign d_valid  = valid_vec[1];
  assign d_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model with a behavioural memory.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  longint cyc = 0;

  // Transaction-level model: memory is free from cycle free_at on; one response pending.
  logic [63:0] mem_model [logic [63:0]];
  longint      free_at = 0;
  bit          m_last = 0;
  bit          pend = 0, pend_port = 0, pend_we = 0;
  longint      pend_cyc = 0;
  logic [63:0] pend_data = 0;
  bit          got_if_gnt, got_d_gnt;
  bit          hold_if = 0, hold_d = 0;

  longint if_gnt_q[$], d_gnt_q[$], if_val_q[$], d_val_q[$];
  int     n_mem_en = 0;

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[31:0] ^ 32'hA5C3_0F1E, ~a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit          g_any, g_port;
    logic [6:0]  e_flags;
    logic [63:0] e_addr, e_wdata, e_if_rd, e_d_rd;
    if (pend && cyc == pend_cyc && !pend_we) mem_rdata = pend_data;
    else mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    g_any = 0; g_port = 0;
    e_flags = '0; e_addr = '0; e_wdata = '0; e_if_rd = '0; e_d_rd = '0;
    if (!reset) begin
      if (cyc >= free_at) begin
        if (if_req && d_req) begin g_any = 1; g_port = !m_last; end
        else if (d_req)      begin g_any = 1; g_port = 1; end
        else if (if_req)     begin g_any = 1; g_port = 0; end
        if (g_any) begin
          e_flags[5] = 1'b1;
          e_flags[4] = g_port & d_we;
          e_flags[3] = !g_port;
          e_flags[2] = g_port;
          e_addr  = g_port ? d_addr : if_addr;
          e_wdata = g_port ? d_wdata : 64'd0;
        end
      end else begin
        e_flags[6] = 1'b1;
        if (pend && cyc == pend_cyc) begin
          if (pend_port) begin e_flags[0] = 1'b1; e_d_rd = pend_we ? 64'd0 : pend_data; end
          else begin e_flags[1] = 1'b1; e_if_rd = pend_data; end
        end
      end
    end
    check("strobes", {57'd0, busy, mem_en, mem_we, if_gnt, d_gnt, if_valid, d_valid}, {57'd0, e_flags});
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("if_rdata", if_rdata, e_if_rd);
    check("d_rdata", d_rdata, e_d_rd);
    if (if_gnt) if_gnt_q.push_back(cyc);
    if (d_gnt) d_gnt_q.push_back(cyc);
    if (if_valid) if_val_q.push_back(cyc);
    if (d_valid) d_val_q.push_back(cyc);
    if (mem_en) n_mem_en++;
    if (reset) begin
      free_at = cyc + 1; m_last = 0; pend = 0;
    end else if (g_any) begin
      free_at = cyc + MEM_LAT + 1; m_last = g_port;
      pend = 1; pend_port = g_port; pend_cyc = cyc + MEM_LAT;
      pend_we = g_port & d_we;
      if (pend_we) mem_model[d_addr] = d_wdata;
      else pend_data = mem_read(g_port ? d_addr : if_addr);
    end else if (pend && cyc == pend_cyc) begin
      pend = 0;
    end
    got_if_gnt = g_any && !g_port;
    got_d_gnt  = g_any && g_port;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (got_if_gnt && !hold_if) if_req = 0;
      if (got_d_gnt && !hold_d) d_req = 0;
    end
  endtask

  task automatic clear_logs();
    if_gnt_q.delete(); d_gnt_q.delete(); if_val_q.delete(); d_val_q.delete();
    n_mem_en = 0;
  endtask

  longint t0;

  initial begin
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    #1;
    // Single fetch, requested during reset: outputs stay 0 until release.
    if_req = 1; if_addr = 64'h10;
    run(2);
    reset = 0; clear_logs(); t0 = cyc;
    run(4);
    check("fetch_gnt_cycle", if_gnt_q.size() == 1 ? if_gnt_q[0] - t0 : -1, 0);
    check("fetch_valid_cycle", if_val_q.size() == 1 ? if_val_q[0] - t0 : -1, 2);

    // Store then load back from the same address.
    d_req = 1; d_we = 1; d_addr = 64'h80; d_wdata = 64'hDEAD; clear_logs(); t0 = cyc;
    run(4);
    check("store_valid_cycle", d_val_q.size() == 1 ? d_val_q[0] - t0 : -1, 2);
    d_req = 1; d_we = 0; d_wdata = 64'h1234;
    run(4);

    // Tie after reset: D, IF, D.
    reset = 1; run(1); reset = 0;
    if_req = 1; if_addr = 64'h200; d_req = 1; d_we = 0; d_addr = 64'h300;
    hold_if = 1; hold_d = 1; clear_logs(); t0 = cyc;
    run(9);
    hold_if = 0; hold_d = 0; if_req = 0; d_req = 0;
    check("tie_d_gnts", d_gnt_q.size(), 2);
    check("tie_d_gnt0", d_gnt_q.size() > 0 ? d_gnt_q[0] - t0 : -1, 0);
    check("tie_if_gnt", if_gnt_q.size() > 0 ? if_gnt_q[0] - t0 : -1, 3);
    check("tie_d_gnt1", d_gnt_q.size() > 1 ? d_gnt_q[1] - t0 : -1, 6);
    run(3);

    // Back-to-back fetches.
    if_req = 1; if_addr = 64'h400; hold_if = 1; clear_logs(); t0 = cyc;
    run(9);
    hold_if = 0; if_req = 0;
    for (int i = 0; i < 3; i++) begin
      check("b2b_gnt", if_gnt_q.size() > i ? if_gnt_q[i] - t0 : -1, 3 * i);
      check("b2b_valid", if_val_q.size() > i ? if_val_q[i] - t0 : -1, 3 * i + 2);
    end

    // Reset mid-transaction: no d_valid, pending fetch granted on release.
    d_req = 1; d_we = 0; d_addr = 64'h88; clear_logs();
    run(1);
    reset = 1; if_req = 1; if_addr = 64'h500;
    run(2);
    reset = 0; t0 = cyc;
    run(4);
    check("rst_no_dvalid", d_val_q.size(), 0);
    check("rst_if_gnt", if_gnt_q.size() > 0 ? if_gnt_q[0] - t0 : -1, 0);

    // Request withdrawn while a fetch is outstanding.
    if_req = 1; if_addr = 64'h600; clear_logs();
    run(1);
    d_req = 1; d_we = 1; d_addr = 64'h90; d_wdata = 64'h77;
    run(1);
    d_req = 0;
    run(3);
    check("withdraw_no_dgnt", d_gnt_q.size(), 0);
    check("withdraw_mem_en", n_mem_en, 1);

    // Random traffic with occasional reset and withdrawals.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!if_req) begin
        if ($urandom_range(0, 1) == 0) begin
          if_req = 1; if_addr = {58'd0, 3'($urandom_range(0, 7)), 3'b000};
        end
      end else if ($urandom_range(0, 9) == 0) if_req = 0;
      if (!d_req) begin
        if ($urandom_range(0, 1) == 0) begin
          d_req = 1; d_we = 1'($urandom); d_addr = {58'd0, 3'($urandom_range(0, 7)), 3'b000};
          d_wdata = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 9) == 0) d_req = 0;
      run(1);
    end
    reset = 0; if_req = 0; d_req = 0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
